sub_3input_pipelined: RTL and testbench

- Streaming 3-operand subtractor: out = in0 - in1 - in2, modulo 2^WIDTH.
- Two registered stages with a valid/ready handshake on input and output, so it can sit in a datapath next to the 3-input adder.
- All I/O is registered or handshake-gated, so timing results and throughput are directly measurable.

---
 rtl/sub_3input_pipelined.sv | 76 +++++++
 tb/tb_sub_3input_pipelined.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_3input_pipelined.sv
// Two-stage streaming subtractor: out = (in0 - in1 - in2) mod 2^WIDTH, valid/ready on both sides.
// Optional out_underflow port enabled by defining SUB_3INPUT_PIPELINED_UNDERFLOW_EN.
module sub_3input_pipelined #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
`ifdef SUB_3INPUT_PIPELINED_UNDERFLOW_EN
    ,
    output logic             out_underflow
`endif
);

    // Handshake: a transfer happens on a rising edge where valid && ready. The whole
    // pipe advances together when the output register is empty or being drained, so
    // in_ready combinationally follows out_ready; while stalled every register holds.
    logic             en;
    logic             v1;
    logic [WIDTH-1:0] r2;

`ifdef SUB_3INPUT_PIPELINED_UNDERFLOW_EN
    logic [WIDTH:0]   d1;
    logic [WIDTH:0]   d1_next;
    logic [WIDTH+1:0] diff;

    assign d1_next = {1'b0, in0} - {1'b0, in1};
    assign diff    = {d1[WIDTH], d1} - {2'b00, r2};
`else
    // Without the flag the sign bits never reach an output, so only the low bits are kept.
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d1_next;
    logic [WIDTH-1:0] diff;

    assign d1_next = in0 - in1;
    assign diff    = d1 - r2;
`endif

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            d1        <= '0;
            r2        <= '0;
            out_valid <= 1'b0;
            out       <= '0;
        end else if (en) begin
            v1        <= in_valid;
            d1        <= d1_next;
            r2        <= in2;
            out_valid <= v1;
            out       <= diff[WIDTH-1:0];
        end
    end

`ifdef SUB_3INPUT_PIPELINED_UNDERFLOW_EN
    // The top bit of the widened difference is the sign of the exact integer result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_underflow <= 1'b0;
        end else if (en) begin
            out_underflow <= diff[WIDTH+1];
        end
    end
`endif

endmodule

// File: tb/tb_sub_3input_pipelined.sv
// Directed bench for sub_3input_pipelined: latency, wrap, back-to-back, backpressure,
// bubbles and mid-stream reset, with an in-order scoreboard on the output side.
module tb_sub_3input_pipelined;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
`ifdef SUB_3INPUT_PIPELINED_UNDERFLOW_EN
    logic             out_underflow;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_deliv  = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             exp_uf_q[$];
    logic [WIDTH-1:0] cur_exp;
    logic             cur_uf;
    logic             stall;
    logic [WIDTH-1:0] held_out;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    sub_3input_pipelined #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in0           (in0),
        .in1           (in1),
        .in2           (in2),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out           (out)
`ifdef SUB_3INPUT_PIPELINED_UNDERFLOW_EN
        ,
        .out_underflow (out_underflow)
`endif
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard (sampled on falling edge) ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_uf_q.delete();
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_out", 32'(out), 32'(held_out));
            end
            if (out_valid && out_ready) begin
                n_deliv++;
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out), 32'hDEAD_BEEF);
                end else begin
                    check("out", 32'(out), 32'(exp_q.pop_front()));
`ifdef SUB_3INPUT_PIPELINED_UNDERFLOW_EN
                    check("underflow", 32'(out_underflow), 32'(exp_uf_q.pop_front()));
`else
                    void'(exp_uf_q.pop_front());
`endif
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                exp_uf_q.push_back(cur_uf);
            end
            stall    = out_valid && !out_ready;
            held_out = out;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] e,
                        input logic uf);
        bit acc;
        acc      = 1'b0;
        in0      = a;
        in1      = b;
        in2      = c;
        cur_exp  = e;
        cur_uf   = uf;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            #1;
            acc = in_ready;
            tick();
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        bit pat[6];
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in0       = '0;
        in1       = '0;
        in2       = '0;
        cur_exp   = '0;
        cur_uf    = 1'b0;
        stall     = 1'b0;
        held_out  = '0;

        // reset, with a set presented during reset that must be discarded
        tick();
        in_valid = 1'b1;
        in0      = 16'd77;
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        check("rst_no_leak", 32'(out_valid), 32'd0);

        // single op and latency
        send(16'd100, 16'd30, 16'd20, 16'd50, 1'b0);
        in_valid = 1'b0;
        check("lat_c1_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_c2_valid", 32'(out_valid), 32'd1);
        check("lat_c2_out", 32'(out), 32'd50);
`ifdef SUB_3INPUT_PIPELINED_UNDERFLOW_EN
        check("lat_c2_uf", 32'(out_underflow), 32'd0);
`endif
        tick();
        check("lat_c3_valid", 32'(out_valid), 32'd0);
        idle(2);

        // wrap-around and sign boundaries
        send(16'h0000, 16'h0001, 16'h0001, 16'hFFFE, 1'b1);
        send(16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 1'b0);
        send(16'h0000, 16'hFFFF, 16'hFFFF, 16'h0002, 1'b1);
        send(16'd5,    16'd10,   16'd20,   16'hFFE7, 1'b1);
        send(16'd30,   16'd10,   16'd20,   16'h0000, 1'b0);
        idle(4);

        // back-to-back
        d0 = n_deliv;
        for (int i = 1; i <= 8; i++) begin
            check("b2b_ready", 32'(in_ready), 32'd1);
            send(16'(i * 10), 16'(i), 16'(i), 16'(8 * i), 1'b0);
            check("b2b_valid", 32'(out_valid), 32'(i >= 2));
        end
        in_valid = 1'b0;
        tick();
        check("b2b_tail_valid", 32'(out_valid), 32'd1);
        tick();
        check("b2b_end_valid", 32'(out_valid), 32'd0);
        check("b2b_count", 32'(n_deliv - d0), 32'd8);
        idle(2);

        // backpressure: stall with both stages full, a pending set waiting at the input
        d0 = n_deliv;
        send(16'd1000, 16'd1, 16'd2, 16'd997,  1'b0);
        send(16'd2000, 16'd3, 16'd4, 16'd1993, 1'b0);
        send(16'd3000, 16'd5, 16'd6, 16'd2989, 1'b0);
        out_ready = 1'b0;
        in0       = 16'd4000;
        in1       = 16'd7;
        in2       = 16'd8;
        cur_exp   = 16'd3985;
        cur_uf    = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_out", 32'(out), 32'd1993);
            tick();
        end
        out_ready = 1'b1;
        tick();
        idle(4);
        check("bp_count", 32'(n_deliv - d0), 32'd4);

        // bubbles: in_valid 1,0,1,0 shows up on out_valid two cycles later
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            in_valid = pat[k];
            in0      = 16'(500 + 16 * k);
            in1      = 16'(k);
            in2      = 16'(2 * k);
            cur_exp  = 16'(500 + 13 * k);
            cur_uf   = 1'b0;
            #1;
            check("bubble_valid", 32'(out_valid), (k >= 2) ? 32'(pat[k-2]) : 32'd0);
            tick();
        end
        idle(2);

        // reset with two sets in flight
        send(16'd40, 16'd1, 16'd2, 16'd37, 1'b0);
        send(16'd50, 16'd3, 16'd4, 16'd43, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in0      = 16'd9;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rstmid_valid", 32'(out_valid), 32'd0);
        check("rstmid_out", 32'(out), 32'd0);
        d0 = n_deliv;
        tick();
        check("rstmid_quiet", 32'(out_valid), 32'd0);
        send(16'd60, 16'd5, 16'd6, 16'd49, 1'b0);
        idle(5);
        check("rstmid_count", 32'(n_deliv - d0), 32'd1);

        check("drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
